regfile_wb_bypass: RTL
======================

Name: regfile_wb_bypass

Overview:
- Architectural register file for the 5-stage pipeline: 32 x 64-bit registers (X0..X31), two read ports for ID, one write port driven by WB.
- Write-side state is sequential and owned by this block. Read side delivers ID operands, bit-sliced as one 32:1 selection per bit per port.
- Adds a same-cycle WB->ID bypass, so a value written in WB is visible to the instruction in ID during that same cycle.
- X31 is XZR: it always reads zero and writes to it are dropped.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, register count; fixed at 32 because addresses are 5 bits.
- ZERO_REG, 31, index hardwired to zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all registers.
- regWrite  in  1  write enable from the WB stage.
- writeReg  in  5  destination register index.
- writeData  in  DATA_W  value to write.
- readReg1  in  5  port-1 source index (Rn).
- readReg2  in  5  port-2 source index (Rm/Rd).
- readData1  out  DATA_W  port-1 operand, combinational.
- readData2  out  DATA_W  port-2 operand, combinational.

Behaviour:
- Storage: regs[0..31]. On posedge clk:
  - if reset: all regs <= 0;
  - else if regWrite && writeReg != ZERO_REG: regs[writeReg] <= writeData.
- Reset dominates regWrite in the same cycle, so no write lands. Reset held for N cycles keeps all regs at 0.
- Reset mid-operation discards any pending write on that edge. After reset drops, the first rising edge with regWrite performs a normal write.
- Reads are combinational with zero latency. For port p in {1,2}:
  - readReg_p == ZERO_REG -> 0, with or without a bypass hit;
  - else if regWrite && writeReg == readReg_p -> writeData (bypass);
  - else -> regs[readReg_p].
- Output values:
  - while reset is asserted, readData follows the same rule (bypass still active) and stored values read 0 after the first reset edge;
  - before the first reset edge, stored contents are undefined (X in simulation);
  - there is no registered output, so outputs have no reset value of their own.
- Both ports may read the same register; both get identical values, including a bypassed value.
- Writes to X31 never update storage. X31 reads are 0 even when writeReg == 31 with regWrite high.
- The write decoder produces a one-hot 32-bit enable, gated by regWrite. At most one register is enabled per cycle, and bit 31 is always 0.
- The read path is a per-bit 32:1 selection, DATA_W lanes per port, followed by the bypass 2:1 and the zero-force.
- Timing: the bypass compare sits on the ID critical path. The 5-bit equality compare and the final 2:1 select must be the last logic before readData.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W (64), REG_ADDR_W (5), ZERO_REG (31);
  - typedef reg_addr_t = logic [4:0];
  - typedef word_t = logic [63:0].
- Sub-module regfile_wr_decoder: takes regWrite and writeReg and produces the 32-bit one-hot write enable, with bit 31 forced to 0. It is the only natural sub-module.
- Storage is a generate loop of DATA_W-wide enable flops, each with synchronous reset.

Test Plan:
- Reset then read all: assert reset 2 cycles, then sweep readReg1/readReg2 over 0..31 -> every read returns 0.
- Basic write/read: write X5 = 0xDEADBEEF_CAFEF00D; next cycle readReg1 = 5 -> readData1 = 0xDEADBEEF_CAFEF00D, and X4/X6 still read 0.
- Same-cycle bypass: X7 holds 0x1. With regWrite=1, writeReg=7, writeData=0x2A and readReg1 = readReg2 = 7 -> both ports show 0x2A in that cycle; after the edge, a stored read also returns 0x2A.
- XZR: regWrite=1, writeReg=31, writeData=all ones, readReg2=31 -> readData2 = 0 in that cycle and every later cycle.
- Reset vs write collision: with X3 = 0x55, assert reset together with regWrite=1, writeReg=3, writeData=0x99 -> after the edge X3 reads 0, not 0x99.
- Disabled write: regWrite=0, writeReg=9, writeData=0x77, readReg1=9 -> readData1 keeps the old X9 value, with no bypass and no update.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants for the register file and its decoder.
// Register addresses are 5 bits wide, so the register count is fixed at 32.
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// One-hot write-enable decoder for the register file write port.
// The XZR enable bit is tied low, so stores to X31 never reach storage.
module regfile_wr_decoder
  import cpu_pkg::*;
(
  input  logic                regWrite,
  input  reg_addr_t           writeReg,
  output logic [NUM_REGS-1:0] wr_en_o
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    if (gi == ZERO_REG) begin : g_zero
      assign wr_en_o[gi] = 1'b0;
    end else begin : g_reg
      assign wr_en_o[gi] = regWrite && (writeReg == REG_ADDR_W'(gi));
    end
  end

endmodule

// File: rtl/regfile_wb_bypass.sv
// 32 x DATA_W architectural register file: one WB write port, two combinational ID read ports.
// A same-cycle WB->ID bypass and an XZR zero-force sit at the very end of each read path.
module regfile_wb_bypass #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [4:0]        writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [4:0]        readReg1,
  input  logic [4:0]        readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  import cpu_pkg::*;

  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];

  regfile_wr_decoder u_wr_decoder (
    .regWrite (regWrite),
    .writeReg (writeReg),
    .wr_en_o  (wr_en)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] reg_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        reg_q <= '0;
      end else if (wr_en[gi]) begin
        reg_q <= writeData;
      end
    end

    assign rf_q[gi] = reg_q;
  end

  logic [DATA_W-1:0] stored1, stored2;
  logic              is_zero1, is_zero2;
  logic              hit1, hit2;

  assign is_zero1 = (readReg1 == 5'(ZERO_REG));
  assign is_zero2 = (readReg2 == 5'(ZERO_REG));

  // Zero-force is folded into the slow array path so the address compare and
  // the bypass 2:1 remain the last logic ahead of readData.
  assign stored1 = is_zero1 ? '0 : rf_q[readReg1];
  assign stored2 = is_zero2 ? '0 : rf_q[readReg2];

  assign hit1 = regWrite && (writeReg == readReg1) && !is_zero1;
  assign hit2 = regWrite && (writeReg == readReg2) && !is_zero2;

  assign readData1 = hit1 ? writeData : stored1;
  assign readData2 = hit2 ? writeData : stored2;

endmodule
